// File: rtl/arb_pkg.sv
// Shared definitions for the 8-way round-robin arbiter: sizes, FSM state
// encoding and small pointer/decode helpers.
package arb_pkg;

    localparam int NUM_REQ = 8;
    localparam int SEL_W   = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    // Advance a priority pointer by one; the 3-bit width gives the mod-8 wrap.
    function automatic logic [SEL_W-1:0] ptr_inc(input logic [SEL_W-1:0] p);
        return p + 3'd1;
    endfunction

    // Binary index to one-hot request position.
    function automatic logic [NUM_REQ-1:0] sel2onehot(input logic [SEL_W-1:0] s);
        return {{(NUM_REQ-1){1'b0}}, 1'b1} << s;
    endfunction

endpackage

// File: rtl/rr_pick_8.sv
// Rotating priority picker: returns the first set bit of vec_i searching
// from ptr_i upward with mod-8 wrap. Purely combinational.
module rr_pick_8
    import arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] vec_i,
    input  logic [SEL_W-1:0]   ptr_i,
    output logic [SEL_W-1:0]   idx_o,
    output logic               found_o
);

    logic [2*NUM_REQ-1:0] dbl;
    logic [2*NUM_REQ-1:0] shifted;
    logic [NUM_REQ-1:0]   rot;
    logic [SEL_W-1:0]     rel_idx;

    assign dbl     = {vec_i, vec_i};
    assign shifted = dbl >> ptr_i;
    assign rot     = shifted[NUM_REQ-1:0];

    // Priority-encode the rotated vector (bit 0 = position ptr_i) and map back.
    always_comb begin
        rel_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) rel_idx = SEL_W'(i);
        end
    end

    assign found_o = |vec_i;
    assign idx_o   = rel_idx + ptr_i;

endmodule

// File: rtl/rr_arbiter_8.sv
// Round-robin arbiter for 8 requesters feeding an 8-way mux select.
// The grant is registered and held until the valid/ready handshake; priority
// rotates past the last served requester, and completed handshakes are counted
// with saturation.
// Optional: define ARB_LOCK_EN to add the lock input, which keeps the current
// grant across handshakes for multi-beat bursts.
module rr_arbiter_8
    import arb_pkg::*;
#(
    parameter int RESET_PTR = 0,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req,
    input  logic                 out_ready,
`ifdef ARB_LOCK_EN
    input  logic                 lock,
`endif
    output logic [SEL_W-1:0]     grant_sel,
    output logic [NUM_REQ-1:0]   grant_onehot,
    output logic                 grant_valid,
    output logic [NUM_REQ-1:0]   req_ack,
    output logic [CNT_WIDTH-1:0] xfer_count
);

    localparam logic [SEL_W-1:0]     RST_PTR = SEL_W'(RESET_PTR);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_e               state_q, state_d;
    logic [SEL_W-1:0]     sel_q, sel_d;
    logic [NUM_REQ-1:0]   onehot_q, onehot_d;
    logic [SEL_W-1:0]     ptr_q, ptr_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    logic                 hs;
    logic                 lock_hold;
    logic [NUM_REQ-1:0]   pick_vec;
    logic [SEL_W-1:0]     pick_ptr;
    logic [SEL_W-1:0]     pick_idx;
    logic                 pick_found;

    assign hs = (state_q == GRANT) && out_ready;

`ifdef ARB_LOCK_EN
    assign lock_hold = lock;
`else
    assign lock_hold = 1'b0;
`endif

    // In IDLE search raw requests from ptr; in GRANT pre-compute the follow-on
    // grant from the remaining requests, starting just past the current one.
    always_comb begin
        pick_vec = req;
        pick_ptr = ptr_q;
        if (state_q == GRANT) begin
            pick_vec = req & ~onehot_q;
            pick_ptr = ptr_inc(sel_q);
        end
    end

    rr_pick_8 u_pick (
        .vec_i   (pick_vec),
        .ptr_i   (pick_ptr),
        .idx_o   (pick_idx),
        .found_o (pick_found)
    );

    // Next-state: issue grants, hold them until the handshake, then rotate.
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        onehot_d = onehot_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d  = GRANT;
                    sel_d    = pick_idx;
                    onehot_d = sel2onehot(pick_idx);
                end
            end
            GRANT: begin
                if (hs) begin
                    if (cnt_q != {CNT_WIDTH{1'b1}}) cnt_d = cnt_q + CNT_ONE;
                    if (!lock_hold) begin
                        ptr_d = ptr_inc(sel_q);
                        if (pick_found) begin
                            sel_d    = pick_idx;
                            onehot_d = sel2onehot(pick_idx);
                        end else begin
                            state_d  = IDLE;
                            onehot_d = '0;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and grant registers; reset drops any grant immediately.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            sel_q    <= '0;
            onehot_q <= '0;
            ptr_q    <= RST_PTR;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            onehot_q <= onehot_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign grant_sel    = sel_q;
    assign grant_onehot = onehot_q;
    assign grant_valid  = (state_q == GRANT);
    assign xfer_count   = cnt_q;
    assign req_ack      = hs ? onehot_q : '0;

endmodule

// File: doc/rr_arbiter_8.md
Name: rr_arbiter_8

Overview:
- Round-robin arbiter for 8 requesters, for example coin channels or result sources.
- Sits directly upstream of the 8-way datapath mux and drives its 3-bit select.
- Holds a registered, stable grant until the downstream consumer accepts it (valid/ready).
- Rotates priority so no requester starves and reports a saturating transfer count.

Parameters:
RESET_PTR, 0, priority pointer value after reset (0..7); index searched first.
CNT_WIDTH, 16, width of the saturating completed-transfer counter.

Ports:
clock  input  1  rising-edge clock.
reset  input  1  asynchronous, active-low reset; single clock domain.
req  input  8  request vector; bit i high means requester i wants the mux path.
out_ready  input  1  downstream accepts the current grant this cycle.
grant_sel  output  3  encoded grant, wired to the 8-way mux select; registered.
grant_onehot  output  8  one-hot copy of grant_sel; all zero when not valid; registered.
grant_valid  output  1  grant_sel is meaningful; registered.
req_ack  output  8  combinational one-hot pulse: grant_onehot gated by grant_valid & out_ready.
xfer_count  output  CNT_WIDTH  completed handshakes, saturating; registered.
lock  input  1  only present when ARB_LOCK_EN is defined.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, grant_valid=0, grant_sel=0, grant_onehot=0.
  - ptr=RESET_PTR, xfer_count=0.
  - Reset asserted mid-grant drops the grant immediately, with no ack.
- Pick function: first set bit of the candidate vector, searching ptr, ptr+1, ... 7, 0, ... with mod-8 wrap.
- States: IDLE, GRANT.
- IDLE:
  - If req!=0, next cycle state=GRANT, grant_sel=pick(req), grant_valid=1.
  - Otherwise stay IDLE.
  - Latency from req rising to grant_valid is 1 cycle.
- GRANT:
  - grant_sel and grant_onehot are held stable while out_ready=0, even if req changes, including the granted req dropping.
  - A dropped request is still delivered; requesters must not withdraw before ack.
- Handshake (grant_valid & out_ready):
  - req_ack[grant_sel]=1 in that cycle.
  - ptr <= grant_sel+1 (7 wraps to 0).
  - xfer_count increments; it holds at all-ones once saturated.
  - Candidate = req with bit grant_sel cleared.
  - If candidate!=0, stay GRANT and load pick(candidate) using the new ptr. This gives back-to-back grants with no bubble.
  - Otherwise go to IDLE with grant_valid=0.
- A requester must drop req the cycle after req_ack. If still high, it is treated as a new request and competes normally.
- If only the just-granted requester remains requesting, IDLE is entered for 1 cycle, then it is re-granted.
- All 8 requesting continuously gives a grant order of ptr, ptr+1, ... wrapping; each requester is served once every 8 transfers.
- No combinational path from req to grant_sel. req_ack is the only combinational output, depending on out_ready.

Optional Feature:
- Macro: ARB_LOCK_EN.
- Defined:
  - The lock input exists.
  - A handshake with lock=1 keeps state=GRANT with the same grant_sel; ptr is unchanged and xfer_count still increments.
  - Used for multi-beat bursts.
  - lock is ignored when no handshake occurs.
- Undefined: the lock port is absent and behaviour is exactly as above.

Decomposition:
- Package arb_pkg holds:
  - NUM_REQ=8 and SEL_W=3.
  - State encodings IDLE=1'b0, GRANT=1'b1.
  - Function or constant for mod-8 pointer increment.
- One natural sub-module: rr_pick_8, purely combinational.
  - Inputs: 8-bit vector and 3-bit ptr.
  - Outputs: 3-bit index and found flag.
  - Implementation: rotate right by ptr, priority-encode, add ptr mod 8.
  - Instantiated once, fed either req or the masked candidate.

Test Plan:
- Reset with RESET_PTR=0, req=8'b0000_0000 -> grant_valid=0, grant_sel=0, xfer_count=0; req=8'b0010_0100 -> next cycle grant_sel=2, grant_onehot=8'h04.
- Hold out_ready=0 for 5 cycles while req changes to 8'h80 -> grant_sel stays 2; then out_ready=1 -> req_ack=8'h04, next grant_sel=7 same edge, ptr=3.
- req=8'hFF constant, out_ready=1 constant -> grant_sel sequence 0,1,2,...,7,0 with grant_valid never dropping; xfer_count=16 after 16 transfers.
- Wrap: ptr=7 (after granting 6), req=8'h41 -> grant 0 before 6; then req=8'h40 only -> grant 6.
- CNT_WIDTH=4, 20 handshakes -> xfer_count saturates at 15; assert reset low mid-GRANT -> grant_valid=0 asynchronously, no req_ack.
- ARB_LOCK_EN defined: grant on 3, handshake with lock=1 for 3 beats while req=8'h18 -> grant_sel=3 all 3 beats; lock=0 handshake -> next grant_sel=4.
